lstm_word_unpacker: RTL and testbench

Downstream data stage of the accelerator's bus-facing register front end. It accepts 32-bit words carrying four packed signed int8 values (weights W/U, bias, x_t or h_t) and buffers them in a small FIFO. It then serialises the buffered words into a stream of single 8-bit elements, with valid/ready handshake, for the LSTM gate MAC datapath. A per-word last flag marks the end of a gate group, for example the last data gate of a timestep.

---
 rtl/lstm_word_unpacker.sv | 223 ++++++++++++++++++++++
 tb/tb_lstm_word_unpacker.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_word_unpacker.sv
// lstm_word_unpacker: buffers 32-bit words of four packed int8 values in a
// small FIFO and serialises them into a valid/ready stream of single elements
// for the LSTM gate MAC datapath. Only lanes enabled by the word's byte enables
// are emitted. The word's last flag is attached to its highest enabled lane.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   clear_i                  synchronous flush; has priority over all other events
//   wr_valid_i/wr_ready_o    word write handshake (wr_ready_o = FIFO not full)
//   wr_data_i, wr_be_i       packed elements (lane k = [8k+7:8k]) and lane enables
//   wr_last_i                word closes a gate group
//   elem_valid_o/elem_ready_i element handshake
//   elem_data_o, elem_last_o current element and its end-of-group flag
//   fill_o                   words held in the FIFO (excludes the unpack register)
//   overflow_o               sticky: enabled write attempted while full
//   elem_cnt_o               elements since last group end (LSTM_UNPACK_CNT_EN only)
//
// Optional feature: define LSTM_UNPACK_CNT_EN to add the saturating element
// counter output elem_cnt_o.
module lstm_word_unpacker #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     wr_valid_i,
  input  logic [31:0]              wr_data_i,
  input  logic [3:0]               wr_be_i,
  input  logic                     wr_last_i,
  output logic                     wr_ready_o,
  output logic                     elem_valid_o,
  output logic [7:0]               elem_data_o,
  output logic                     elem_last_o,
  input  logic                     elem_ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
`ifdef LSTM_UNPACK_CNT_EN
  output logic [CNT_W-1:0]         elem_cnt_o,
`endif
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  if (CNT_W == 0 || DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("lstm_word_unpacker: DEPTH must be a power of two in 2..64 and CNT_W > 0");
  end

  typedef struct packed {
    logic        last;
    logic [3:0]  be;
    logic [31:0] data;
  } word_t;

  typedef enum logic {IDLE, UNPACK} state_e;

  // Index of the lowest enabled lane; 0 when no lane is enabled.
  function automatic logic [1:0] low_lane(input logic [3:0] be);
    logic [1:0] lane;
    lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (be[i]) lane = 2'(i);
    end
    return lane;
  endfunction

  word_t          mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]  fill_q, fill_d;
  logic           wr_ready_q;
  logic           overflow_q;

  state_e         state_q, state_d;
  logic [31:0]    word_data_q, word_data_d;
  logic [3:0]     rem_q, rem_d;       // enabled lanes not yet handshaked, incl. current
  logic           wlast_q, wlast_d;
  logic           elem_valid_q, elem_valid_d;
  logic [7:0]     elem_data_q, elem_data_d;
  logic           elem_last_q, elem_last_d;

  logic           push, pop, empty, hs, final_lane;
  logic [1:0]     cur_lane, lane_d;
  word_t          head;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign push       = wr_valid_i & wr_ready_q & (|wr_be_i) & ~clear_i;
  assign hs         = elem_valid_q & elem_ready_i;
  assign cur_lane   = low_lane(rem_q);
  assign final_lane = ((rem_q & ~(4'b0001 << cur_lane)) == 4'b0000);

  // FIFO storage (no reset needed: validity is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{last: wr_last_i, be: wr_be_i, data: wr_data_i};
  end

  // Fill level tracks push/pop so wr_ready can be registered.
  always_comb begin
    fill_d = fill_q;
    if (clear_i) fill_d = '0;
    else if (push && !pop) fill_d = fill_q + FW'(1);
    else if (!push && pop) fill_d = fill_q - FW'(1);
  end

  // FIFO pointers, fill, ready and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      wr_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      wr_ready_q <= (fill_d != FW'(DEPTH));
      if (clear_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + FW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + FW'(1);
        if (wr_valid_i && !wr_ready_q && (|wr_be_i)) overflow_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!empty) state_d = UNPACK;
        UNPACK:  if (hs && final_lane && empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: pop decision, unpack register update and next element.
  always_comb begin
    pop         = 1'b0;
    word_data_d = word_data_q;
    rem_d       = rem_q;
    wlast_d     = wlast_q;
    if (clear_i) begin
      rem_d = 4'b0000;
    end else begin
      case (state_q)
        IDLE:   pop = !empty;
        UNPACK: begin
          if (hs) begin
            if (!final_lane) rem_d = rem_q & ~(4'b0001 << cur_lane);
            else if (!empty) pop = 1'b1;     // back-to-back word, no bubble
            else             rem_d = 4'b0000;
          end
        end
        default: pop = 1'b0;
      endcase
    end
    if (pop) begin
      word_data_d = head.data;
      rem_d       = head.be;
      wlast_d     = head.last;
    end
    lane_d       = low_lane(rem_d);
    elem_valid_d = (state_d == UNPACK);
    elem_data_d  = elem_valid_d ? word_data_d[{lane_d, 3'b000} +: 8] : 8'h00;
    elem_last_d  = elem_valid_d & wlast_d & ((rem_d & ~(4'b0001 << lane_d)) == 4'b0000);
  end

  // Unpack register and registered element outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_data_q  <= '0;
      rem_q        <= '0;
      wlast_q      <= 1'b0;
      elem_valid_q <= 1'b0;
      elem_data_q  <= '0;
      elem_last_q  <= 1'b0;
    end else begin
      word_data_q  <= word_data_d;
      rem_q        <= rem_d;
      wlast_q      <= wlast_d;
      elem_valid_q <= elem_valid_d;
      elem_data_q  <= elem_data_d;
      elem_last_q  <= elem_last_d;
    end
  end

`ifdef LSTM_UNPACK_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Elements since the last group end; saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt_q <= '0;
    else if (clear_i)               cnt_q <= '0;
    else if (hs) begin
      if (elem_last_q)              cnt_q <= '0;
      else if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign elem_cnt_o = cnt_q;
`endif

  assign wr_ready_o   = wr_ready_q;
  assign elem_valid_o = elem_valid_q;
  assign elem_data_o  = elem_data_q;
  assign elem_last_o  = elem_last_q;
  assign fill_o       = fill_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_lstm_word_unpacker.sv
// Self-checking bench for lstm_word_unpacker: directed scenarios plus random
// traffic, with every emitted element compared against a queue of expected
// elements built from the accepted words' enabled lanes.
module tb_lstm_word_unpacker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_i;
  logic          wr_valid_i;
  logic [31:0]   wr_data_i;
  logic [3:0]    wr_be_i;
  logic          wr_last_i;
  logic          wr_ready_o;
  logic          elem_valid_o;
  logic [7:0]    elem_data_o;
  logic          elem_last_o;
  logic          elem_ready_i;
  logic [FW-1:0] fill_o;
  logic          overflow_o;
`ifdef LSTM_UNPACK_CNT_EN
  logic [CNT_W-1:0] elem_cnt_o;
`endif

  always #5 clk = ~clk;

  lstm_word_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_be_i      (wr_be_i),
    .wr_last_i    (wr_last_i),
    .wr_ready_o   (wr_ready_o),
    .elem_valid_o (elem_valid_o),
    .elem_data_o  (elem_data_o),
    .elem_last_o  (elem_last_o),
    .elem_ready_i (elem_ready_i),
    .fill_o       (fill_o),
`ifdef LSTM_UNPACK_CNT_EN
    .elem_cnt_o   (elem_cnt_o),
`endif
    .overflow_o   (overflow_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } elem_t;

  elem_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an accepted word contributes its enabled lanes in
  // ascending order; only the highest enabled lane carries the word's last.
  task automatic model_word(input logic [31:0] d, input logic [3:0] be, input logic last);
    int    top;
    elem_t e;
    top = -1;
    for (int i = 0; i < 4; i++) if (be[i]) top = i;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        e.data = d[8*i +: 8];
        e.last = last && (i == top);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write for the coming edge and record it if it will be taken.
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] be, input logic last);
    wr_valid_i = v;
    wr_data_i  = d;
    wr_be_i    = be;
    wr_last_i  = last;
    if (v && wr_ready_o && be != 4'd0 && !clear_i && rst) model_word(d, be, last);
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] be, input logic last);
    drive(1'b1, d, be, last);
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic drain();
    elem_ready_i = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !elem_valid_o) break;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(elem_valid_o), 32'd0);
    tick();
  endtask

  // Queue n full words under backpressure, then handshake one element so
  // the unpack register is mid-word.
  task automatic stall_fill(input int n);
    elem_ready_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive(1'b1, $urandom, 4'hF, 1'b0);
      tick();
    end
    wr_valid_i   = 1'b0;
    elem_ready_i = 1'b1;
    tick();
    elem_ready_i = 1'b0;
  endtask

  // Output monitor: scoreboard on handshakes, stability while stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  always @(negedge clk) begin
    if (!rst || clear_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(elem_valid_o), 32'd1);
        check("stall_data",  32'(elem_data_o), 32'(prev_data));
        check("stall_last",  32'(elem_last_o), 32'(prev_last));
      end
      if (elem_valid_o && elem_ready_i) begin
        if (exp_q.size() == 0) begin
          check("elem_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          elem_t e;
          e = exp_q.pop_front();
          check("elem_data", 32'(elem_data_o), 32'(e.data));
          check("elem_last", 32'(elem_last_o), 32'(e.last));
        end
      end
      prev_stall = elem_valid_o && !elem_ready_i;
      prev_data  = elem_data_o;
      prev_last  = elem_last_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int streak;
    int acc;

    rst          = 1'b0;
    clear_i      = 1'b0;
    wr_valid_i   = 1'b0;
    wr_data_i    = '0;
    wr_be_i      = '0;
    wr_last_i    = 1'b0;
    elem_ready_i = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_valid",    32'(elem_valid_o), 32'd0);
    check("rst_data",     32'(elem_data_o),  32'd0);
    check("rst_last",     32'(elem_last_o),  32'd0);
    check("rst_wr_ready", 32'(wr_ready_o),   32'd1);
    check("rst_fill",     32'(fill_o),       32'd0);
    check("rst_overflow", 32'(overflow_o),   32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic unpack: first element two cycles after the write, then gapless.
    elem_ready_i = 1'b1;
    write_word(32'h807F_0201, 4'hF, 1'b0);
    @(negedge clk);
    check("lat_valid_e1", 32'(elem_valid_o), 32'd0);
    check("lat_fill_e1",  32'(fill_o),       32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_valid", 32'(elem_valid_o), 32'd1);
    end
    @(negedge clk);
    check("basic_done_valid", 32'(elem_valid_o), 32'd0);
    check("basic_done_fill",  32'(fill_o),       32'd0);
    tick();

    // Sparse lanes with last on the highest enabled lane.
    write_word(32'hAABB_CCDD, 4'b0101, 1'b1);
    drain();

    // A word with no enabled lanes is dropped silently.
    write_word($urandom, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("be0_valid", 32'(elem_valid_o), 32'd0);
    end
    check("be0_fill",     32'(fill_o),     32'd0);
    check("be0_overflow", 32'(overflow_o), 32'd0);
    tick();

    // Backpressure until full, then overflow on the extra write.
    elem_ready_i = 1'b0;
    acc = 0;
    for (int k = 0; k < int'(DEPTH) + 2; k++) begin
      if (wr_ready_o) acc++;
      drive(1'b1, $urandom, 4'hF, 1'(k == int'(DEPTH)));
      tick();
    end
    wr_valid_i = 1'b0;
    @(negedge clk);
    check("full_accepted", 32'(acc),          32'(DEPTH + 1));
    check("full_fill",     32'(fill_o),       32'(DEPTH));
    check("full_wr_ready", 32'(wr_ready_o),   32'd0);
    check("full_overflow", 32'(overflow_o),   32'd1);
    check("full_valid",    32'(elem_valid_o), 32'd1);
    tick();
    elem_ready_i = 1'b1;
    streak = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!elem_valid_o) break;
      streak++;
    end
    check("stream_len", 32'(streak), 32'(4 * (DEPTH + 1)));
    tick();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      elem_ready_i = 1'($urandom_range(0, 2) != 0);
      drive(1'($urandom_range(0, 2) != 0), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      tick();
    end
    wr_valid_i = 1'b0;
    drain();

    // Synchronous clear mid-word with a concurrent write.
    write_word($urandom, 4'hF, 1'b0);
    write_word($urandom, 4'hF, 1'b0);
    drain();
    stall_fill(4);
    check("pre_clear_overflow", 32'(overflow_o), 32'd1);
    clear_i = 1'b1;
    drive(1'b1, 32'h1234_5678, 4'hF, 1'b1);
    exp_q.delete();
    tick();
    clear_i    = 1'b0;
    wr_valid_i = 1'b0;
    @(negedge clk);
    check("clr_valid",    32'(elem_valid_o), 32'd0);
    check("clr_fill",     32'(fill_o),       32'd0);
    check("clr_overflow", 32'(overflow_o),   32'd0);
    check("clr_wr_ready", 32'(wr_ready_o),   32'd1);
    elem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clr_write_absent", 32'(elem_valid_o), 32'd0);
    end
    tick();

    // Asynchronous reset pulse of half a cycle mid-word with a concurrent write.
    stall_fill(int'(DEPTH) + 2);
    check("pre_rst_overflow", 32'(overflow_o), 32'd1);
    rst = 1'b0;
    drive(1'b1, 32'h8765_4321, 4'hF, 1'b1);
    exp_q.delete();
    #5;
    rst        = 1'b1;
    wr_valid_i = 1'b0;
    @(negedge clk);
    check("arst_valid",    32'(elem_valid_o), 32'd0);
    check("arst_fill",     32'(fill_o),       32'd0);
    check("arst_overflow", 32'(overflow_o),   32'd0);
    check("arst_wr_ready", 32'(wr_ready_o),   32'd1);
    elem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_write_absent", 32'(elem_valid_o), 32'd0);
    end
    tick();

`ifdef LSTM_UNPACK_CNT_EN
    // Counter runs 0..11 across a 3-word group and returns to 0.
    begin
      int idx;
      elem_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, $urandom, 4'hF, 1'(k == 2));
        tick();
      end
      wr_valid_i   = 1'b0;
      elem_ready_i = 1'b1;
      idx = 0;
      for (int c = 0; c < 100 && idx < 12; c++) begin
        @(negedge clk);
        if (elem_valid_o && elem_ready_i) begin
          check("elem_cnt", 32'(elem_cnt_o), 32'(idx));
          idx++;
        end
      end
      check("cnt_handshakes", 32'(idx), 32'd12);
      @(negedge clk);
      check("elem_cnt_wrap", 32'(elem_cnt_o), 32'd0);
      tick();
    end
`endif

    drain();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
